// File: rtl/seg7_scan_8digit.sv
// Eight-digit multiplexed 7-segment scanner: buffers eight nibbles and time-slices them onto
// active-low anodes/cathodes, REFRESH_DIV clocks per digit. Optional macro: LEADING_ZERO_BLANK_EN.
module seg7_scan_8digit #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       load,
    input  logic [3:0] D [7:0],
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       scanning
);
    localparam int             PW      = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0]  PRE_MAX = PW'(REFRESH_DIV - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_buf [7:0];
    logic [PW-1:0] r_pre;
    logic [2:0]    r_idx;
    logic [7:0]    r_an;
    logic [6:0]    r_seg;
    logic          w_tick;
    logic          w_blank;
    logic [3:0]    w_digit;
    logic [7:0]    w_an_nxt;
    logic [6:0]    w_seg_nxt;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // SCAN is only left through reset
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == IDLE && load) w_state_nxt = SCAN;
    end

    assign w_tick = (r_state == SCAN) && en && (r_pre == PRE_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 8; k++) r_buf[k] <= 4'd0;
            r_pre <= '0;
            r_idx <= 3'd0;
        end else begin
            if (load) begin
                for (int k = 0; k < 8; k++) r_buf[k] <= D[k];
            end
            if (r_state == IDLE) begin
                r_pre <= '0;
                r_idx <= 3'd0;
            end else if (w_tick) begin
                r_pre <= '0;
                r_idx <= r_idx + 3'd1;
            end else if (en) begin
                r_pre <= r_pre + 1'b1;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [7:0] w_zero;
    logic [7:0] w_below;
    always_comb begin
        for (int k = 0; k < 8; k++) w_zero[k] = (r_buf[k] == 4'd0);
    end
    // digit idx is a leading zero when it and every higher digit are zero
    assign w_below = (8'd1 << r_idx) - 8'd1;
    assign w_blank = (r_idx != 3'd0) && ((w_zero | w_below) == 8'hFF);
`else
    assign w_blank = 1'b0;
`endif

    assign w_digit = r_buf[r_idx];

    always_comb begin
        w_an_nxt  = 8'hFF;
        w_seg_nxt = 7'h7F;
        if (r_state == SCAN && en && !w_blank) begin
            w_an_nxt  = ~(8'd1 << r_idx);
            w_seg_nxt = hex7(w_digit);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_an  <= 8'hFF;
            r_seg <= 7'h7F;
        end else begin
            r_an  <= w_an_nxt;
            r_seg <= w_seg_nxt;
        end
    end

    assign an       = r_an;
    assign seg      = r_seg;
    assign scanning = (r_state == SCAN);
endmodule

// File: tb/tb_seg7_scan_8digit.sv
// Bench for seg7_scan_8digit at REFRESH_DIV=4: directed stimulus pushes hand-derived expected
// outputs into a queue; a monitor pops one entry per clock and compares.
module tb_seg7_scan_8digit;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [3:0] tb_D [7:0];
    logic [7:0] an;
    logic [6:0] seg;
    logic       scanning;

    typedef struct {
        logic [7:0] an;
        logic [6:0] seg;
        logic       sc;
        string      nm;
    } exp_t;

    exp_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    seg7_scan_8digit #(.REFRESH_DIV(4)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .D(tb_D),
        .an(an), .seg(seg), .scanning(scanning)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] hx(input logic [3:0] v);
        logic [6:0] tbl [16];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return tbl[v];
    endfunction

    // Drive inputs for the coming edge and record what the outputs must be after it
    task automatic step(input logic r, input logic e, input logic l,
                        input logic [7:0] xa, input logic [6:0] xs, input logic xsc,
                        input string nm);
        exp_t x;
        @(negedge clk);
        rst = r; en = e; load = l;
        x.an = xa; x.seg = xs; x.sc = xsc; x.nm = nm;
        q.push_back(x);
    endtask

    task automatic slot(input int k, input logic [3:0] v, input int n, input string nm);
        logic [7:0] a;
        a = ~(8'd1 << k);
        repeat (n) step(1'b0, 1'b1, 1'b0, a, hx(v), 1'b1, nm);
    endtask

    task automatic blank_or_zero(input int k, input string nm);
`ifdef LEADING_ZERO_BLANK_EN
        repeat (4) step(1'b0, 1'b1, 1'b0, 8'hFF, 7'h7F, 1'b1, nm);
        if (k < 0) $display("unreachable");
`else
        slot(k, 4'd0, 4, nm);
`endif
    endtask

    task automatic set_d(input logic [3:0] d7, input logic [3:0] d6, input logic [3:0] d5,
                         input logic [3:0] d4, input logic [3:0] d3, input logic [3:0] d2,
                         input logic [3:0] d1, input logic [3:0] d0);
        tb_D[7] = d7; tb_D[6] = d6; tb_D[5] = d5; tb_D[4] = d4;
        tb_D[3] = d3; tb_D[2] = d2; tb_D[1] = d1; tb_D[0] = d0;
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                n_total++;
                if (an !== x.an || seg !== x.seg || scanning !== x.sc)
                    $display("FAIL %s: got an=%h seg=%h scanning=%b, want an=%h seg=%h scanning=%b",
                             x.nm, an, seg, scanning, x.an, x.seg, x.sc);
                else
                    n_pass++;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout want completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        set_d(0, 0, 0, 0, 0, 0, 0, 0);

        repeat (2) step(1'b1, 1'b0, 1'b0, 8'hFF, 7'h7F, 1'b0, "reset");
        repeat (50) step(1'b0, 1'b1, 1'b0, 8'hFF, 7'h7F, 1'b0, "idle_noload");

        // first load: outputs still blank on the load edge, scanning rises
        set_d(7, 6, 5, 4, 3, 2, 1, 0);
        step(1'b0, 1'b1, 1'b1, 8'hFF, 7'h7F, 1'b1, "load1");
        for (int k = 0; k < 8; k++) slot(k, 4'(k), 4, "scan_pass1");
        for (int k = 0; k < 3; k++) slot(k, 4'(k), 4, "scan_wrap");

        // drop en one clock into slot 3; the three remaining clocks follow on resume
        slot(3, 4'd3, 1, "slot3_pre_pause");
        repeat (10) step(1'b0, 1'b0, 1'b0, 8'hFF, 7'h7F, 1'b1, "en_off");
        slot(3, 4'd3, 3, "slot3_resume");
        slot(4, 4'd4, 3, "slot4");

        // load on the tick edge that leaves slot 4
        set_d(4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8);
        step(1'b0, 1'b1, 1'b1, 8'hEF, hx(4'd4), 1'b1, "load_on_tick");
        for (int k = 5; k < 8; k++) slot(k, 4'(k + 8), 4, "new_data");
        for (int k = 0; k < 5; k++) slot(k, 4'(k + 8), 4, "new_data_wrap");
        slot(5, 4'hD, 2, "slot5_before_rst");

        step(1'b1, 1'b1, 1'b0, 8'hFF, 7'h7F, 1'b0, "rst_mid_scan");
        step(1'b1, 1'b1, 1'b1, 8'hFF, 7'h7F, 1'b0, "load_during_rst");
        step(1'b0, 1'b1, 1'b0, 8'hFF, 7'h7F, 1'b0, "idle_after_rst");

        set_d(4'h0, 4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9);
        step(1'b0, 1'b1, 1'b1, 8'hFF, 7'h7F, 1'b1, "reload");
        slot(0, 4'h9, 4, "restart_slot0");
        slot(1, 4'hA, 4, "restart_slot1");
        slot(2, 4'hB, 4, "restart_slot2");

        // leading-zero pattern 0,0,0,0,0,0,1,0
        step(1'b1, 1'b1, 1'b0, 8'hFF, 7'h7F, 1'b0, "rst_lz");
        set_d(0, 0, 0, 0, 0, 0, 1, 0);
        step(1'b0, 1'b1, 1'b1, 8'hFF, 7'h7F, 1'b1, "load_lz");
        slot(0, 4'd0, 4, "lz_digit0");
        slot(1, 4'd1, 4, "lz_digit1");
        for (int k = 2; k < 8; k++) blank_or_zero(k, "lz_upper");

        // all zeros: only digit 0 survives blanking
        step(1'b1, 1'b1, 1'b0, 8'hFF, 7'h7F, 1'b0, "rst_zero");
        set_d(0, 0, 0, 0, 0, 0, 0, 0);
        step(1'b0, 1'b1, 1'b1, 8'hFF, 7'h7F, 1'b1, "load_zero");
        slot(0, 4'd0, 4, "zero_digit0");
        for (int k = 1; k < 8; k++) blank_or_zero(k, "zero_upper");

        @(negedge clk);
        repeat (3) @(posedge clk);
        #2;
        n_total++;
        if (q.size() != 0)
            $display("FAIL drain: got %0d pending entries, want 0", q.size());
        else
            n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/seg7_scan_8digit.md
SEG7_SCAN_8DIGIT -- requirements
Module: seg7_scan_8digit

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, giving clocks per digit slot; legal range 2..2^20.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port en, input, 1 bit: scan enable.
REQ-005 SHALL have port load, input, 1 bit: one-cycle pulse that captures D into the display buffer.
REQ-006 SHALL have port D, input, 8 x 4 bit unpacked array [3:0] D[7:0]: nibbles from the upstream 16x4 shift register's Q outputs, D[0] = rightmost digit.
REQ-007 SHALL have port an, output, 8 bits: active-low digit anodes, an[k] drives digit k.
REQ-008 SHALL have port seg, output, 7 bits: active-low cathodes, seg[6:0] = g f e d c b a.
REQ-009 SHALL have port scanning, output, 1 bit: high while the FSM is in SCAN.

Function
REQ-010 SHALL hold an 8 x 4-bit buffer; when load=1, the buffer takes D on that edge; otherwise the buffer holds.
REQ-011 SHALL have a prescaler counting 0..REFRESH_DIV-1, advancing only while en=1 in state SCAN; tick = (prescaler == REFRESH_DIV-1) && en; prescaler wraps to 0 on tick.
REQ-012 SHALL have a 3-bit digit index idx that increments on tick and wraps 7 -> 0.
REQ-013 SHALL implement FSM IDLE/SCAN: IDLE -> SCAN on load=1; SCAN -> IDLE never (only reset); in IDLE, prescaler and idx held at 0.
REQ-014 SHALL register an and seg every clock from the current idx and buffer, giving one-cycle latency from idx/buffer change to the outputs.
REQ-015 SHALL in SCAN with en=1 drive an = all ones except an[idx]=0, and seg = hex code of buffer[idx].
REQ-016 SHALL, in IDLE or with en=0, drive an=8'hFF and seg=7'h7F; with en=0, prescaler and idx hold their values.
REQ-017 SHALL use hex codes (seg hex): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
REQ-018 SHALL, when load and tick occur on the same edge, both capture the buffer and advance idx; the next output cycle shows the new buffer at the new idx.
REQ-019 SHALL ignore load while rst=1; rst has priority over all inputs.

Reset
REQ-020 SHALL on rst=1 at a clock edge set: buffer all 0, prescaler 0, idx 0, FSM IDLE, an=8'hFF, seg=7'h7F, scanning=0.
REQ-021 SHALL on rst asserted mid-scan return to the state in REQ-020 on that edge, with no partial digit retained.

Configuration
REQ-022 SHALL provide macro LEADING_ZERO_BLANK_EN; when defined, digit k (k>=1) SHALL be blanked (an[k]=1, seg=7'h7F during its slot) if buffer[k] and all buffer[j] for j>k are 0; digit 0 is never blanked.
REQ-023 SHALL, without LEADING_ZERO_BLANK_EN, display all 8 digits including leading zeros; slot timing SHALL be identical in both builds.

Verification (REFRESH_DIV=4)
REQ-024 SHALL cover this scenario: reset, then no load for 50 clocks -> an=FF, seg=7F, scanning=0 throughout.
REQ-025 SHALL cover this scenario: load with D[7:0]=7,6,5,4,3,2,1,0 and en=1 -> scanning=1; an cycles FE,FD,...,7F, each held 4 clocks; seg matches code(idx); wraps after 32 clocks.
REQ-026 SHALL cover this scenario: en dropped for 10 clocks in slot 3 -> an=FF, seg=7F; on en=1, the scan resumes at slot 3 with remaining prescaler count intact.
REQ-027 SHALL cover this scenario: load of new D coincident with a tick -> the next slot shows the new value; there is no glitch cycle with old data.
REQ-028 SHALL cover this scenario: with LEADING_ZERO_BLANK_EN, buffer = 0,0,0,0,0,0,1,0 (D[7]..D[0]) -> digits 7..2 blank, digit 1 shows 79, digit 0 shows 40; all zeros -> only digit 0 lit, showing 40.
REQ-029 SHALL cover this scenario: rst pulsed during slot 5 -> the next cycle shows an=FF, scanning=0, buffer cleared, and a following load restarts at slot 0.
